fpnew_noncomp_wb: RTL and testbench
===================================

// Module: fpnew_noncomp_wb
// PURPOSE
// - Writeback stage directly downstream of the non-computational FP unit (sgnj/minmax/cmp/classify).
// - Widens the unit's WIDTH-bit result to the Width-bit register-file word:
//   - NaN-boxing or sign-extension, driven by the extension bit.
//   - Class mask is turned into an integer result.
// - Buffers results in a 2-entry skid buffer with valid/ready handshake and flush.
// - Accumulates sticky exception flags (fflags) over retired results.
// PARAMETERS
// - FpFormat : fpnew_pkg::FP32 ; source format; WIDTH = fpnew_pkg::fp_width(FpFormat)
// - Width    : 64              ; output word width; elaboration error if Width < WIDTH or Width < 10
// - TagType  : logic           ; opaque tag carried alongside each result
// PORTS
// - clk_i            in   1        clock
// - rst_ni           in   1        asynchronous active-low reset
// - result_i         in   WIDTH    result from the noncomp unit
// - status_i         in   status_t exception flags of result_i (NV,DZ,OF,UF,NX)
// - extension_bit_i  in   1        value replicated into the upper bits
// - class_mask_i     in   10       classmask_e; used when is_class_i=1
// - is_class_i       in   1        result is a classification
// - tag_i            in   TagType  tag
// - in_valid_i       in   1        input valid
// - in_ready_o       out  1        input ready
// - flush_i          in   1        discard all buffered entries
// - result_o         out  Width    widened result
// - status_o         out  status_t flags of the head entry
// - tag_o            out  TagType  tag of the head entry
// - out_valid_o      out  1        head entry valid
// - out_ready_i      in   1        consumer ready
// - fflags_o         out  status_t sticky OR of status of retired entries
// - fflags_clr_i     in   1        clear sticky flags
// - busy_o           out  1        any entry valid
// BEHAVIOUR
// - Entry = {result[Width-1:0], status, tag}. Widening is computed before storage:
//   - is_class_i=1: result = zero-extended class_mask_i.
//   - otherwise: result = {{(Width-WIDTH){extension_bit_i}}, result_i}.
// - Accept on in_valid_i & in_ready_o. Retire on out_valid_o & out_ready_i.
// - Storage: main register (drives outputs) and skid register.
//   - Latency: accept in cycle N -> visible on outputs in N+1.
// - in_ready_o = ~skid_valid_q. It is registered state only, with no combinational path from out_ready_i.
// - Next-state rules:
//   - main empty or retiring, skid empty: an accepted entry loads main.
//   - main full and not retiring: an accepted entry loads skid.
//   - main retiring and skid full: skid moves to main, skid empties, no accept (in_ready_o=0).
// - FIFO order is always preserved; the skid register never drives the outputs.
// - flush_i (highest priority): main and skid invalid next cycle, and no accept that cycle.
//   - A retire in the flush cycle still counts toward fflags.
// - fflags_d = (fflags_clr_i ? '0 : fflags_q) | (retire ? status_o : '0).
//   - A clear in the same cycle as a retire keeps only the retiring flags.
// - busy_o = main_valid_q | skid_valid_q.
// - Reset values: out_valid_o=0, result_o='0, status_o='0, tag_o='0, fflags_o='0, in_ready_o=1, busy_o=0.
//   - Reset mid-transfer drops all entries.
// - Data registers are updated only on load. No X may reach the outputs after reset.
// STRUCTURE
// - Types come from fpnew_pkg: status_t, classmask_e, fp_width().
// - Add fpnew_pkg function widen_result(...) so other writeback stages share the widening logic.
// - No sub-module: two instances of a local packed entry struct plus the control logic.
// TESTING (FpFormat=FP32, Width=64)
// - Float passthrough: result_i=32'h3F80_0000, ext=1, is_class=0 -> next cycle result_o=64'hFFFF_FFFF_3F80_0000, out_valid_o=1.
// - Comparison: result_i=32'h1, ext=0 -> result_o=64'h0000_0000_0000_0001. Sign-extend: result_i=32'hBF80_0000, ext=1 -> upper word 32'hFFFF_FFFF.
// - Classify: class_mask_i=POSNORM (10'h040), is_class=1, result_i=32'hDEAD_BEEF -> result_o=64'h40.
// - Backpressure:
//   - out_ready_i=0; send A, B, C back-to-back -> A, B accepted, in_ready_o=0 from the cycle after B, C held.
//   - Then out_ready_i=1 -> A, B, C retire in order, one per cycle.
// - fflags:
//   - Retire status NV (5'b10000), then NX (5'b00001) -> fflags_o=5'b10001.
//   - Retire OF with fflags_clr_i=1 in the same cycle -> fflags_o=5'b00100.
// - Flush:
//   - Both entries full, assert flush_i -> next cycle out_valid_o=0, busy_o=0, in_ready_o=1, fflags_o unchanged.
//   - Assert rst_ni low with entries full -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Shared FP types and the result-widening helper for the non-computational writeback stages.
// Carries no state or handshake: all declarations are combinational and zero-latency.
package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  // Widest register-file word any writeback stage may request.
  localparam int unsigned MAX_WIDTH = 128;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  typedef enum logic [9:0] {
    NEGINF     = 10'h001,
    NEGNORM    = 10'h002,
    NEGSUBNORM = 10'h004,
    NEGZERO    = 10'h008,
    POSZERO    = 10'h010,
    POSSUBNORM = 10'h020,
    POSNORM    = 10'h040,
    POSINF     = 10'h080,
    SNAN       = 10'h100,
    QNAN       = 10'h200
  } classmask_e;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    case (fmt)
      FP32:    return 32;
      FP64:    return 64;
      FP16:    return 16;
      FP8:     return 8;
      FP16ALT: return 16;
      default: return 32;
    endcase
  endfunction

  // Bits at or above src_width take ext_bit (NaN-box / sign-extend); class results are zero-extended.
  function automatic logic [MAX_WIDTH-1:0] widen_result(
    input logic [MAX_WIDTH-1:0] result,
    input int unsigned          src_width,
    input logic                 ext_bit,
    input classmask_e           class_mask,
    input logic                 is_class
  );
    logic [MAX_WIDTH-1:0] wide;
    wide = '0;
    if (is_class) begin
      wide[9:0] = class_mask;
    end else begin
      for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
        wide[i] = (i < src_width) ? result[i] : ext_bit;
      end
    end
    return wide;
  endfunction

endpackage

// File: rtl/fpnew_noncomp_wb.sv
// Widens noncomp FP results into a 2-entry skid buffer; accept in N is visible on outputs in N+1.
// in_ready_o is purely registered (low only while the skid entry is occupied); sticky fflags over retires.
module fpnew_noncomp_wb
  import fpnew_pkg::*;
#(
  parameter fp_format_e  FpFormat = FP32,
  parameter int unsigned Width    = 64,
  parameter type         TagType  = logic
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [fp_width(FpFormat)-1:0]      result_i,
  input  status_t                            status_i,
  input  logic                               extension_bit_i,
  input  classmask_e                         class_mask_i,
  input  logic                               is_class_i,
  input  TagType                             tag_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic                               flush_i,
  output logic [Width-1:0]                   result_o,
  output status_t                            status_o,
  output TagType                             tag_o,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output status_t                            fflags_o,
  input  logic                               fflags_clr_i,
  output logic                               busy_o
);

  localparam int unsigned WIDTH = fp_width(FpFormat);

  if (Width < WIDTH || Width < 10 || Width > MAX_WIDTH) begin : g_bad_width
    $error("fpnew_noncomp_wb: Width must be >= source width, >= 10 and <= MAX_WIDTH");
  end

  typedef struct packed {
    logic [Width-1:0] result;
    status_t          status;
    TagType           tag;
  } entry_t;

  entry_t               main_q, skid_q, in_entry;
  logic                 main_valid_q, skid_valid_q;
  logic                 accept, retire;
  logic                 main_load, skid_load;
  logic                 main_valid_d, skid_valid_d;
  logic [MAX_WIDTH-1:0] res_pad, res_wide;
  logic                 unused_wide;
  status_t              fflags_q, fflags_d;

  always_comb begin
    res_pad              = '0;
    res_pad[WIDTH-1:0]   = result_i;
    res_wide             = widen_result(res_pad, WIDTH, extension_bit_i, class_mask_i, is_class_i);
    in_entry.result      = res_wide[Width-1:0];
    in_entry.status      = status_i;
    in_entry.tag         = tag_i;
  end

  // Only part of the widened word is kept when Width < MAX_WIDTH.
  assign unused_wide = ^res_wide;

  assign in_ready_o = ~skid_valid_q;
  assign accept     = in_valid_i & in_ready_o & ~flush_i;
  assign retire     = main_valid_q & out_ready_i;

  // Main reloads from skid when it drains; otherwise from input when it is free.
  assign main_load  = ~flush_i & (skid_valid_q ? retire : (accept & (~main_valid_q | retire)));
  assign skid_load  = ~flush_i & accept & main_valid_q & ~retire;

  assign main_valid_d = ~flush_i & ((main_valid_q & ~retire) | main_load);
  assign skid_valid_d = ~flush_i & ((skid_valid_q & ~retire) | skid_load);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q <= '0;
    end else if (main_load) begin
      main_q <= skid_valid_q ? skid_q : in_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_q <= '0;
    end else if (skid_load) begin
      skid_q <= in_entry;
    end
  end

  // A retire in a flush cycle still contributes its flags.
  assign fflags_d = (fflags_clr_i ? '0 : fflags_q) | (retire ? main_q.status : '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fflags_q <= '0;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  assign result_o    = main_q.result;
  assign status_o    = main_q.status;
  assign tag_o       = main_q.tag;
  assign out_valid_o = main_valid_q;
  assign fflags_o    = fflags_q;
  assign busy_o      = main_valid_q | skid_valid_q;

  skid_implies_main: assert property (@(posedge clk_i) disable iff (!rst_ni)
    skid_valid_q |-> main_valid_q);

endmodule

// File: tb/tb_fpnew_noncomp_wb.sv
// Scoreboard bench for fpnew_noncomp_wb (FP32 -> 64-bit).
module tb_fpnew_noncomp_wb;
  import fpnew_pkg::*;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  status;
    logic [7:0]  tag;
  } tb_entry_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] result_i;
  status_t     status_i;
  logic        extension_bit_i;
  classmask_e  class_mask_i;
  logic        is_class_i;
  logic [7:0]  tag_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        flush_i;
  logic [63:0] result_o;
  status_t     status_o;
  logic [7:0]  tag_o;
  logic        out_valid_o;
  logic        out_ready_i;
  status_t     fflags_o;
  logic        fflags_clr_i;
  logic        busy_o;

  tb_entry_t   sb[$];
  tb_entry_t   cur_exp;
  logic [4:0]  exp_ff;
  logic        last_acc;
  int          n_checks = 0;
  int          n_pass   = 0;

  fpnew_noncomp_wb #(
    .FpFormat (FP32),
    .Width    (64),
    .TagType  (logic [7:0])
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .result_i        (result_i),
    .status_i        (status_i),
    .extension_bit_i (extension_bit_i),
    .class_mask_i    (class_mask_i),
    .is_class_i      (is_class_i),
    .tag_i           (tag_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .flush_i         (flush_i),
    .result_o        (result_o),
    .status_o        (status_o),
    .tag_o           (tag_o),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .fflags_o        (fflags_o),
    .fflags_clr_i    (fflags_clr_i),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input logic [31:0] res, input logic ext, input logic [9:0] mask,
                       input logic is_cls, input logic [4:0] st, input logic [7:0] tg);
    result_i        = res;
    extension_bit_i = ext;
    class_mask_i    = classmask_e'(mask);
    is_class_i      = is_cls;
    status_i        = st;
    tag_i           = tg;
    in_valid_i      = 1'b1;
    cur_exp.result  = is_cls ? {54'b0, mask} : {{32{ext}}, res};
    cur_exp.status  = st;
    cur_exp.tag     = tg;
  endtask

  // Called at a negedge with inputs set; returns at the following negedge.
  task automatic step();
    logic      acc, ret;
    tb_entry_t e;
    logic [4:0] ret_st;
    #1;
    acc    = in_valid_i & in_ready_o & ~flush_i;
    ret    = out_valid_o & out_ready_i;
    ret_st = '0;
    if (ret) begin
      if (sb.size() == 0) begin
        check("retire_with_empty_model", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        ret_st = e.status;
        check("retire_result", result_o, e.result);
        check("retire_status", 64'(status_o), 64'(e.status));
        check("retire_tag", 64'(tag_o), 64'(e.tag));
      end
    end
    exp_ff = (fflags_clr_i ? 5'b0 : exp_ff) | ret_st;
    if (flush_i) sb.delete();
    if (acc) sb.push_back(cur_exp);
    last_acc = acc;
    @(posedge clk_i);
    @(negedge clk_i);
    check("out_valid", 64'(out_valid_o), 64'(sb.size() != 0));
    check("busy", 64'(busy_o), 64'(sb.size() != 0));
    check("in_ready", 64'(in_ready_o), 64'(sb.size() < 2));
    check("fflags", 64'(fflags_o), 64'(exp_ff));
  endtask

  initial begin
    rst_ni = 1'b0; result_i = '0; status_i = '0; extension_bit_i = 1'b0;
    class_mask_i = POSZERO; is_class_i = 1'b0; tag_i = '0; in_valid_i = 1'b0;
    flush_i = 1'b0; out_ready_i = 1'b0; fflags_clr_i = 1'b0;
    exp_ff = '0; last_acc = 1'b0; cur_exp = '0;
    repeat (2) @(negedge clk_i);
    check("rst_out_valid", 64'(out_valid_o), 64'(0));
    check("rst_result", result_o, 64'(0));
    check("rst_status", 64'(status_o), 64'(0));
    check("rst_tag", 64'(tag_o), 64'(0));
    check("rst_fflags", 64'(fflags_o), 64'(0));
    check("rst_in_ready", 64'(in_ready_o), 64'(1));
    check("rst_busy", 64'(busy_o), 64'(0));
    rst_ni = 1'b1;
    step();

    // Directed widening vectors, one result in flight at a time.
    out_ready_i = 1'b1;
    drive(32'h3F80_0000, 1'b1, 10'h000, 1'b0, 5'b0, 8'h01); step(); in_valid_i = 1'b0;
    check("fp_pass_valid", 64'(out_valid_o), 64'(1));
    check("fp_pass", result_o, 64'hFFFF_FFFF_3F80_0000);
    drive(32'h0000_0001, 1'b0, 10'h000, 1'b0, 5'b0, 8'h02); step(); in_valid_i = 1'b0;
    check("cmp_result", result_o, 64'h0000_0000_0000_0001);
    drive(32'hBF80_0000, 1'b1, 10'h000, 1'b0, 5'b0, 8'h03); step(); in_valid_i = 1'b0;
    check("sext_upper", 64'(result_o[63:32]), 64'hFFFF_FFFF);
    drive(32'hDEAD_BEEF, 1'b0, 10'h040, 1'b1, 5'b0, 8'h04); step(); in_valid_i = 1'b0;
    check("classify", result_o, 64'h40);
    step();

    // Backpressure: A and B buffered, C held until space frees.
    out_ready_i = 1'b0;
    drive(32'hA, 1'b0, 10'h0, 1'b0, 5'b0, 8'hA0); step();
    drive(32'hB, 1'b0, 10'h0, 1'b0, 5'b0, 8'hB0); step();
    check("bp_ready_after_b", 64'(in_ready_o), 64'(0));
    drive(32'hC, 1'b0, 10'h0, 1'b0, 5'b0, 8'hC0); step();
    check("bp_c_held", 64'(last_acc), 64'(0));
    step();
    out_ready_i = 1'b1;
    step();
    check("bp_head_b", 64'(tag_o), 64'hB0);
    step();
    check("bp_c_accept", 64'(last_acc), 64'(1));
    in_valid_i = 1'b0;
    step();
    check("bp_drained", 64'(busy_o), 64'(0));

    // Sticky flags.
    fflags_clr_i = 1'b1; step(); fflags_clr_i = 1'b0;
    drive(32'h1, 1'b0, 10'h0, 1'b0, 5'b10000, 8'h10); step();
    drive(32'h2, 1'b0, 10'h0, 1'b0, 5'b00001, 8'h11); step();
    in_valid_i = 1'b0; step(); step();
    check("ff_nv_nx", 64'(fflags_o), 64'h11);
    out_ready_i = 1'b0;
    drive(32'h3, 1'b0, 10'h0, 1'b0, 5'b00100, 8'h12); step();
    in_valid_i = 1'b0; out_ready_i = 1'b1; fflags_clr_i = 1'b1; step(); fflags_clr_i = 1'b0;
    check("ff_clr_with_retire", 64'(fflags_o), 64'h04);

    // Flush with both entries full.
    out_ready_i = 1'b0;
    drive(32'h20, 1'b0, 10'h0, 1'b0, 5'b01000, 8'h20); step();
    drive(32'h21, 1'b0, 10'h0, 1'b0, 5'b01000, 8'h21); step();
    check("fl_full_busy", 64'(busy_o), 64'(1));
    drive(32'h22, 1'b0, 10'h0, 1'b0, 5'b0, 8'h22);
    flush_i = 1'b1; step(); flush_i = 1'b0; in_valid_i = 1'b0;
    check("fl_out_valid", 64'(out_valid_o), 64'(0));
    check("fl_busy", 64'(busy_o), 64'(0));
    check("fl_in_ready", 64'(in_ready_o), 64'(1));
    check("fl_fflags_kept", 64'(fflags_o), 64'h04);

    // Flush while retiring and while input is offered: retire counts, input dropped.
    drive(32'h30, 1'b0, 10'h0, 1'b0, 5'b01000, 8'h30); step();
    drive(32'h31, 1'b0, 10'h0, 1'b0, 5'b00010, 8'h31);
    out_ready_i = 1'b1; flush_i = 1'b1; step(); flush_i = 1'b0; in_valid_i = 1'b0;
    check("fl_no_accept", 64'(last_acc), 64'(0));
    check("fl_retire_flags", 64'(fflags_o), 64'h0C);
    check("fl_retire_busy", 64'(busy_o), 64'(0));

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      out_ready_i  = ($urandom_range(0, 3) != 0);
      fflags_clr_i = ($urandom_range(0, 15) == 0);
      if (!in_valid_i && $urandom_range(0, 1) == 1)
        drive($urandom, 1'($urandom_range(0, 1)), 10'(1 << $urandom_range(0, 9)),
              ($urandom_range(0, 3) == 0), 5'($urandom), 8'($urandom));
      step();
      if (last_acc) in_valid_i = 1'b0;
    end
    in_valid_i = 1'b0; fflags_clr_i = 1'b0; out_ready_i = 1'b1;
    repeat (3) step();
    check("rand_drained", 64'(sb.size()), 64'(0));

    // Asynchronous reset with both entries full.
    out_ready_i = 1'b0;
    drive(32'h50, 1'b1, 10'h0, 1'b0, 5'b11111, 8'h50); step();
    drive(32'h51, 1'b1, 10'h0, 1'b0, 5'b11111, 8'h51); step();
    in_valid_i = 1'b0; out_ready_i = 1'b1; step();
    check("pre_rst_fflags", 64'(fflags_o), 64'h1F);
    out_ready_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid_o), 64'(0));
    check("arst_result", result_o, 64'(0));
    check("arst_status", 64'(status_o), 64'(0));
    check("arst_tag", 64'(tag_o), 64'(0));
    check("arst_fflags", 64'(fflags_o), 64'(0));
    check("arst_in_ready", 64'(in_ready_o), 64'(1));
    check("arst_busy", 64'(busy_o), 64'(0));
    sb.delete();
    exp_ff = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
